// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU and its issue controller:
// ALU control codes, compact request opcodes and the issue FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XNOR = 4'b0101;
  localparam logic [3:0] ALU_SHL  = 4'b0110;
  localparam logic [3:0] ALU_SHR  = 4'b0111;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of the 3-bit request opcode into the ALU control code.
// Opcode 111 is reported as illegal and maps to NOP.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [3:0] aluctrl,
  output logic       illegal
);

  always_comb begin
    aluctrl = ALU_NOP;
    illegal = 1'b0;
    case (op)
      OP_ADD:  aluctrl = ALU_ADD;
      OP_SUB:  aluctrl = ALU_SUB;
      OP_AND:  aluctrl = ALU_AND;
      OP_OR:   aluctrl = ALU_OR;
      OP_XNOR: aluctrl = ALU_XNOR;
      OP_SHL:  aluctrl = ALU_SHL;
      OP_SHR:  aluctrl = ALU_SHR;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Request/response sequencer for the one-cycle-latency registered ALU.
// Define ALU_ISSUE_PERF_EN to add saturating perf_ops/perf_ovf counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_z,
  input  logic                  alu_ovf,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_ovf,
  output logic                  rsp_err
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [15:0]           perf_ops,
  output logic [15:0]           perf_ovf
`endif
);

  issue_state_t state, state_nx;
  logic [3:0]   dec_ctrl;
  logic         dec_ill;
  logic         req_hs;
  logic         rsp_hs;

  alu_op_decode u_dec (
    .op      (req_op),
    .aluctrl (dec_ctrl),
    .illegal (dec_ill)
  );

  assign req_hs = (state == ST_IDLE) && req_valid && req_ready;
  assign rsp_hs = (state == ST_RESP) && rsp_valid && rsp_ready;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_hs) state_nx = dec_ill ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  state_nx = ST_RESP;
      ST_RESP:  if (rsp_hs) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // req_ready is registered, so it is derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= ALU_NOP;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      req_ready <= (state_nx == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            if (dec_ill) begin
              rsp_data  <= '0;
              rsp_ovf   <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              alu_a    <= req_a;
              alu_b    <= req_b;
              alu_ctrl <= dec_ctrl;
            end
          end
        end
        ST_ISSUE: alu_ctrl <= ALU_NOP;
        ST_WAIT: begin
          rsp_data  <= alu_z;
          rsp_ovf   <= alu_ovf;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
        end
        ST_RESP: if (rsp_hs) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops <= '0;
      perf_ovf <= '0;
    end else if (rsp_hs) begin
      perf_ops <= sat_inc(perf_ops);
      if (rsp_ovf) perf_ovf <= sat_inc(perf_ovf);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a one-cycle registered ALU model.
// Build with ALU_ISSUE_PERF_EN defined to also check the perf counters.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_z;
  logic         alu_ovf;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_ovf;
  logic         rsp_err;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0]  perf_ops, perf_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int exp_ops = 0;
  int exp_ovf = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_z     (alu_z),
    .alu_ovf   (alu_ovf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_ovf  (perf_ovf)
`endif
  );

  // Registered ALU: samples inputs on the edge, result visible one cycle later.
  always_ff @(posedge clk) begin
    alu_ovf <= 1'b0;
    case (alu_ctrl)
      ALU_ADD:  {alu_ovf, alu_z} <= {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB:  alu_z <= alu_a - alu_b;
      ALU_AND:  alu_z <= alu_a & alu_b;
      ALU_OR:   alu_z <= alu_a | alu_b;
      ALU_XNOR: alu_z <= ~(alu_a ^ alu_b);
      ALU_SHL:  alu_z <= alu_a << 1;
      ALU_SHR:  alu_z <= alu_a >> 1;
      default:  alu_z <= '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic exp_o, input logic exp_e,
                       input int stall);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = (stall == 0);
    step();
    req_valid = 1'b0;
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (exp_e) begin
      chk("ill_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("ill_vld_e1", {31'd0, rsp_valid}, 32'd1);
    end else begin
      chk("issue_ctrl", {28'd0, alu_ctrl}, {29'd0, op} + 32'd1);
      chk("issue_a", alu_a, a);
      chk("issue_b", alu_b, b);
      chk("vld_e0", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("ctrl_nop_e1", {28'd0, alu_ctrl}, 32'd0);
      chk("a_hold_e1", alu_a, a);
      chk("vld_e1", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("vld_e2", {31'd0, rsp_valid}, 32'd1);
    end
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, exp_o});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_op    = OP_OR;
      step();
      chk("stall_vld", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, exp_d);
      chk("stall_req_rdy", {31'd0, req_ready}, 32'd0);
      chk("stall_ctrl", {28'd0, alu_ctrl}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    exp_ops++;
    if (exp_o) exp_ovf++;
    chk("hs_vld_clr", {31'd0, rsp_valid}, 32'd0);
    chk("hs_req_rdy", {31'd0, req_ready}, 32'd1);
    chk("hs_data_keep", rsp_data, exp_d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    step();
    rst = 1'b0;
    step();

    do_op(OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 0);
    do_op(OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 0);
    do_op(OP_XNOR, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF00FF00F, 1'b0, 1'b0, 0);
    do_op(OP_ILL,  32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b0, 1'b1, 0);
    do_op(OP_SHL,  32'h80000001, 32'h1,        32'h00000002, 1'b0, 1'b0, 3);
    do_op(OP_SHR,  32'h80000001, 32'h1,        32'h40000000, 1'b0, 1'b0, 0);

    // Reset while an AND sits in WAIT.
    req_valid = 1'b1;
    req_op    = OP_AND;
    req_a     = 32'hF0F0F0F0;
    req_b     = 32'hFF00FF00;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("mid_rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    exp_ops = 0;
    exp_ovf = 0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_vld", {31'd0, rsp_valid}, 32'd0);
    end

    do_op(OP_OR,  32'd1,        32'd2, 32'd3,        1'b0, 1'b0, 0);
    do_op(OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0,        1'b1, 1'b0, 0);
    do_op(OP_ADD, 32'd2,        32'd3, 32'd5,        1'b0, 1'b0, 0);
    do_op(OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 0);
    do_op(OP_ILL, 32'd9,        32'd9, 32'd0,        1'b0, 1'b1, 0);

`ifdef ALU_ISSUE_PERF_EN
    chk("perf_ops", {16'd0, perf_ops}, exp_ops);
    chk("perf_ovf", {16'd0, perf_ovf}, exp_ovf);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
